// File: rtl/button_press_encoder.sv
// Button front-end: sync, debounce, press-edge detect, and
// encode four buttons into one indexed valid/ready event stream.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   btn_raw      raw button levels (async), 1 = pressed
//   press_ready  consumer accepts the pending event
//   press_valid  event pending in the output register
//   press_idx    index of the pressed button (lowest wins)
//   press_multi  several press edges landed in the same cycle
//   btn_level    debounced stable level per button
//   overflow     sticky: an event was dropped
//
// Optional: define BPE_REPEAT_EN for auto-repeat of held
// buttons every REPEAT_CYCLES clocks.

module button_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int REPEAT_CYCLES   = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_idx,
    output logic       press_multi,
    output logic [3:0] btn_level,
    output logic       overflow
);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_chk_db
        $error("DEBOUNCE_CYCLES out of range");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_chk_cw
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_chk_rep
        $error("REPEAT_CYCLES must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            s1;
    logic [3:0]            s2;
    logic [3:0][CNT_W-1:0] cnt;
    logic [3:0]            level_d;
    logic [3:0]            rise;
    logic [3:0]            ev;
    logic [1:0]            cand_idx;
    logic                  cand_any;
    logic                  cand_multi;

    // Two-flop synchroniser
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            btn_level <= '0;
            level_d   <= '0;
        end else begin
            level_d <= btn_level;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = btn_level & ~level_d;

`ifdef BPE_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST =
        REP_W'(REPEAT_CYCLES - 1);

    logic [3:0][REP_W-1:0] rcnt;
    logic [3:0]            rep;

    always_comb begin
        rep = '0;
        for (int i = 0; i < 4; i++) begin
            rep[i] = btn_level[i] & ~rise[i] &
                     (rcnt[i] == REP_LAST);
        end
    end

    // Repeat counter restarts at every press edge and
    // whenever it wraps, giving a fixed repeat period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!btn_level[i] || rise[i] ||
                    rcnt[i] == REP_LAST) begin
                    rcnt[i] <= '0;
                end else begin
                    rcnt[i] <= rcnt[i] + REP_W'(1);
                end
            end
        end
    end

    assign ev = rise | rep;
`else
    assign ev = rise;
`endif

    // Lowest set index wins; higher ones are discarded.
    always_comb begin
        cand_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (ev[i]) cand_idx = 2'(i);
        end
    end

    assign cand_any   = |ev;
    assign cand_multi = |(ev & (ev - 4'd1));

    // Output register: reload when empty or draining.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_valid <= 1'b0;
            press_idx   <= '0;
            press_multi <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (!press_valid || press_ready) begin
                press_valid <= cand_any;
                if (cand_any) begin
                    press_idx   <= cand_idx;
                    press_multi <= cand_multi;
                end
            end else if (cand_any) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/button_press_encoder.md
Name: button_press_encoder

Overview:
- Front-end for the four player push-buttons of the whack-a-mole game.
- Per button: synchronises the raw input, debounces it, and detects the press (rising) edge.
- Encodes presses into one indexed event stream with a valid/ready handshake.
- The game state machine consumes this stream instead of raw buttons, so it sees exactly one event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clocks a synchronised level must differ from the stable level before the stable level flips. Legal range 2..65535.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 1024: auto-repeat period in clocks. Used only when BPE_REPEAT_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  4  raw button levels, asynchronous to clock, 1 = pressed.
- press_ready  input  1  consumer accepts the event this cycle.
- press_valid  output  1  an event is pending in the output register.
- press_idx  output  2  index (0..3) of the pressed button.
- press_multi  output  1  more than one button produced a press edge in the same cycle as this event.
- btn_level  output  4  debounced stable level of each button.
- overflow  output  1  sticky; an event was dropped.

Behaviour:
- Clock and reset: one clock, clock. Reset is asynchronous and active-high, port reset. On assertion all registers clear immediately: synchronisers, counters, btn_level = 0, press_valid = 0, press_idx = 0, press_multi = 0, overflow = 0.
- Synchroniser: 2 flops per button, s1 <= btn_raw, s2 <= s1.
- Debounce, per button, on each clock:
  - s2 == btn_level: cnt <= 0.
  - s2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
  - Consequence: any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is rejected.
- Edge detect:
  - rise[i] = btn_level[i] & ~level_d[i], where level_d is btn_level delayed by one clock.
  - Release edges generate no event.
- Encode:
  - If any rise bit is set, the candidate event is the lowest set index.
  - cand_multi = 1 if two or more rise bits are set; the higher-index presses are discarded.
- Output register and handshake:
  - Load the candidate when press_valid == 0, or when press_valid & press_ready in the same cycle (back-to-back, no bubble).
  - press_valid & press_ready with no candidate: press_valid <= 0.
  - Candidate present while press_valid & ~press_ready: candidate dropped, overflow <= 1. The pending event, press_idx and press_multi stay unchanged.
  - press_idx and press_multi hold stable while press_valid = 1 and press_ready = 0.
  - overflow clears only on reset.
- Latency: btn_raw rising before clock edge 1 and held → btn_level[i] = 1 after edge DEBOUNCE_CYCLES+2, press_valid = 1 after edge DEBOUNCE_CYCLES+3. Release latency to btn_level = 0 is the same, DEBOUNCE_CYCLES+2.
- Held button: produces exactly one event, unless BPE_REPEAT_EN is defined.
- Reset mid-operation: a press still held when reset deasserts re-debounces from 0 and produces a new event after full latency. A pending event is lost.

Optional Feature:
- Macro: BPE_REPEAT_EN.
- Defined:
  - Each button has a repeat counter, cleared while btn_level[i] = 0 and on each rise[i].
  - While btn_level[i] = 1, the counter increments. On reaching REPEAT_CYCLES-1 it sets a repeat pulse rep[i] for one clock and returns to 0.
  - Encoder input becomes rise | rep, with the same priority and multi rules.
- Undefined: no repeat logic is instantiated, and the parameter REPEAT_CYCLES is ignored.

Test Plan (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 8):
- Reset then idle: all outputs 0. btn_raw = 4'b0100 held, press_ready = 1 → press_valid = 1 for exactly one cycle, 7 edges after first sampling, with press_idx = 2, press_multi = 0, btn_level = 4'b0100.
- Bounce: btn_raw[1] pulses high for 3 clocks, low for 2, high for 3 → no event, btn_level stays 0. Then held 10 clocks → exactly one event, press_idx = 1.
- Simultaneous: btn_raw 0 → 4'b1010 in one cycle → single event, press_idx = 1, press_multi = 1, btn_level = 4'b1010.
- Backpressure: press_ready = 0. Press button 0 (event pending), release, then press button 3 → press_valid stays 1, press_idx = 0, overflow = 1. Raise press_ready → button-0 event accepted, press_valid = 0 next cycle.
- Back-to-back: event pending with press_ready = 1 in the same cycle a new rise on button 2 appears → press_valid stays 1, press_idx = 2 next cycle, overflow = 0.
- Async reset mid-debounce: assert reset with cnt = 2 on button 0 → all outputs 0 immediately, without a clock edge. With BPE_REPEAT_EN defined and button 3 held after the first event: further events with press_idx = 3 every 8 clocks until release.
